vga_timing: RTL and testbench
=============================

// Module: vga_timing
// PURPOSE
// - Free-running VGA raster timing generator for the 1024x768@60 display (65 MHz pixel clock).
// - Produces hcount/vcount, sync and blanking on a vga_if.out bundle, plus a one-cycle frame strobe.
// - First stage of the video chain; its output feeds draw_bg directly.
// PARAMETERS
// - HOR_PIXELS     1024  visible pixels per line (from vga_pkg)
// - HOR_FRONT       24   horizontal front porch, clocks
// - HOR_SYNC       136   hsync pulse width, clocks
// - HOR_TOTAL     1344   clocks per line
// - VER_PIXELS     768   visible lines per frame (from vga_pkg)
// - VER_FRONT        3   vertical front porch, lines
// - VER_SYNC         6   vsync pulse width, lines
// - VER_TOTAL      806   lines per frame
// PORTS
// - clk         in   1        pixel clock, 65 MHz
// - rst         in   1        synchronous reset, active-high
// - vga_out     out  vga_if   modport out: vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]
// - frame_start out  1        one-cycle pulse when hcount==0 and vcount==0
// BEHAVIOUR
// - Reset and clock: reset rst, synchronous, active-high; clock clk.
// - All outputs are registered.
// - While rst=1, all of these are 0: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb and frame_start.
// - First cycle after reset release: hcount=0, vcount=0, frame_start=1.
// - Horizontal count: hcount increments by 1 every clk.
//   - At hcount==HOR_TOTAL-1 it wraps to 0.
// - Vertical count: vcount increments only on the cycle hcount wraps.
//   - On a wrap with vcount==VER_TOTAL-1, vcount also wraps to 0.
//   - hcount and vcount wrap on the same edge.
// - Next-state flags: sync, blank and frame_start are decoded from the next-state counters.
//   - They are registered alongside the counts, so every flag is coherent with the hcount/vcount on the same cycle.
//   - No skew between count and flag.
// - hblnk = 1 iff hcount >= HOR_PIXELS, i.e. 1024..1343.
// - hsync = 1 iff HOR_PIXELS+HOR_FRONT <= hcount < HOR_PIXELS+HOR_FRONT+HOR_SYNC, i.e. 1048..1183.
// - vblnk = 1 iff vcount >= VER_PIXELS, i.e. 768..805.
// - vsync = 1 iff VER_PIXELS+VER_FRONT <= vcount < VER_PIXELS+VER_FRONT+VER_SYNC, i.e. 771..776.
// - Sync polarity: sync flags are active-high pulses; the top level inverts them for the monitor's negative polarity.
// - rgb is held at 12'h000; downstream stages own colour.
// - Width rules: counters are 11 bits, compared unsigned.
//   - Counter width must cover HOR_TOTAL-1 and VER_TOTAL-1; an elaboration-time assertion enforces this.
// - Reset mid-frame: the next edge forces all outputs to 0. The raster restarts at (0,0) with frame_start on release.
// - No enable and no back-pressure: downstream stages must keep pace with one pixel per clk.
// - Period: 1344 clocks per line; 1344*806 = 1 083 264 clocks per frame.
// STRUCTURE
// - vga_pkg: HOR_PIXELS and VER_PIXELS already live there.
//   - Add HOR_TOTAL_DEF, HOR_FRONT_DEF, HOR_SYNC_DEF, VER_TOTAL_DEF, VER_FRONT_DEF, VER_SYNC_DEF as parameter defaults.
//   - Add the 11-bit counter width constant.
// - Single module holding two counters, next-state decode and an output register bank.
// - No sub-module; a generic counter would add nothing.
// TESTING
// - Reset: hold rst 5 clks then release -> cycle 1 shows hcount=0, vcount=0, frame_start=1, all flags 0.
// - Line wrap: at hcount=1343/vcount=0, next clk -> hcount=0, vcount=1, hblnk 1->0.
// - Horizontal decode: over one line -> hsync high exactly at hcount 1048..1183 (136 clks), hblnk high at 1024..1343 (320 clks).
// - Vertical decode: over one frame -> vblnk high at vcount 768..805, vsync high at vcount 771..776 (6*1344 clks).
// - Frame period: count clks between frame_start pulses -> exactly 1 083 264, with no other frame_start in between.
// - Mid-frame reset: assert rst at hcount=500, vcount=400 for 1 clk -> next edge all outputs 0; after release hcount=0, vcount=0, frame_start=1.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants for the 1024x768@60 video chain.
// Revision    : 1.1 - add timing defaults and counter width
// ============================================================================
package vga_pkg;

  localparam int HOR_PIXELS    = 1024;
  localparam int VER_PIXELS    = 768;

  localparam int HOR_TOTAL_DEF = 1344;
  localparam int HOR_FRONT_DEF = 24;
  localparam int HOR_SYNC_DEF  = 136;
  localparam int VER_TOTAL_DEF = 806;
  localparam int VER_FRONT_DEF = 3;
  localparam int VER_SYNC_DEF  = 6;

  localparam int CNT_WIDTH     = 11;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_if
// Description : Raster position, sync, blanking and colour bundle between stages.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
  import vga_pkg::*;

  cnt_t        vcount;
  logic        vsync;
  logic        vblnk;
  cnt_t        hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Free-running raster generator; counts and flags registered together.
// Revision    : 1.1 - next-state flag decode, frame strobe
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int HOR_PIXELS = vga_pkg::HOR_PIXELS,
  parameter int HOR_FRONT  = HOR_FRONT_DEF,
  parameter int HOR_SYNC   = HOR_SYNC_DEF,
  parameter int HOR_TOTAL  = HOR_TOTAL_DEF,
  parameter int VER_PIXELS = vga_pkg::VER_PIXELS,
  parameter int VER_FRONT  = VER_FRONT_DEF,
  parameter int VER_SYNC   = VER_SYNC_DEF,
  parameter int VER_TOTAL  = VER_TOTAL_DEF
) (
  input  logic   clk,
  input  logic   rst,
  vga_if.out     vga_out,
  output logic   frame_start
);

  generate
    if ((HOR_TOTAL - 1) >= (1 << CNT_WIDTH) || (VER_TOTAL - 1) >= (1 << CNT_WIDTH))
    begin : g_width_check
      $error("vga_timing: CNT_WIDTH cannot hold HOR_TOTAL-1 / VER_TOTAL-1");
    end
    if ((HOR_PIXELS + HOR_FRONT + HOR_SYNC) > HOR_TOTAL ||
        (VER_PIXELS + VER_FRONT + VER_SYNC) > VER_TOTAL)
    begin : g_geometry_check
      $error("vga_timing: active + porch + sync exceeds total");
    end
  endgenerate

  localparam cnt_t c_hor_last    = cnt_t'(HOR_TOTAL - 1);
  localparam cnt_t c_ver_last    = cnt_t'(VER_TOTAL - 1);
  localparam cnt_t c_hblnk_start = cnt_t'(HOR_PIXELS);
  localparam cnt_t c_hsync_start = cnt_t'(HOR_PIXELS + HOR_FRONT);
  localparam cnt_t c_hsync_end   = cnt_t'(HOR_PIXELS + HOR_FRONT + HOR_SYNC);
  localparam cnt_t c_vblnk_start = cnt_t'(VER_PIXELS);
  localparam cnt_t c_vsync_start = cnt_t'(VER_PIXELS + VER_FRONT);
  localparam cnt_t c_vsync_end   = cnt_t'(VER_PIXELS + VER_FRONT + VER_SYNC);

  // r_run is clear for the first edge after reset so the raster starts at (0,0)
  logic r_run;
  cnt_t r_hcount;
  cnt_t r_vcount;
  logic r_hsync;
  logic r_vsync;
  logic r_hblnk;
  logic r_vblnk;
  logic r_frame_start;

  cnt_t w_hnext;
  cnt_t w_vnext;
  logic w_hwrap;

  always_comb begin
    w_hwrap = (r_hcount == c_hor_last);
    w_hnext = '0;
    w_vnext = '0;
    if (r_run) begin
      w_hnext = w_hwrap ? '0 : r_hcount + cnt_t'(1);
      w_vnext = r_vcount;
      if (w_hwrap) begin
        w_vnext = (r_vcount == c_ver_last) ? '0 : r_vcount + cnt_t'(1);
      end
    end
  end

  // Flags decode the next-state counts so they land on the same edge as the counts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run         <= 1'b0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_hcount      <= w_hnext;
      r_vcount      <= w_vnext;
      r_hblnk       <= (w_hnext >= c_hblnk_start);
      r_hsync       <= (w_hnext >= c_hsync_start) && (w_hnext < c_hsync_end);
      r_vblnk       <= (w_vnext >= c_vblnk_start);
      r_vsync       <= (w_vnext >= c_vsync_start) && (w_vnext < c_vsync_end);
      r_frame_start <= (w_hnext == '0) && (w_vnext == '0);
    end
  end

  assign vga_out.hcount = r_hcount;
  assign vga_out.vcount = r_vcount;
  assign vga_out.hsync  = r_hsync;
  assign vga_out.vsync  = r_vsync;
  assign vga_out.hblnk  = r_hblnk;
  assign vga_out.vblnk  = r_vblnk;
  assign vga_out.rgb    = 12'h000;
  assign frame_start    = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_timing
// Description : Scoreboard bench for full-size and reduced-geometry raster timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;
  import vga_pkg::*;

  localparam int S_HP = 16;
  localparam int S_HF = 2;
  localparam int S_HS = 4;
  localparam int S_HT = 26;
  localparam int S_VP = 10;
  localparam int S_VF = 1;
  localparam int S_VS = 2;
  localparam int S_VT = 15;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs_full;
  logic fs_small;

  vga_if if_full ();
  vga_if if_small ();

  vga_timing u_full (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (if_full),
    .frame_start (fs_full)
  );

  vga_timing #(
    .HOR_PIXELS (S_HP), .HOR_FRONT (S_HF), .HOR_SYNC (S_HS), .HOR_TOTAL (S_HT),
    .VER_PIXELS (S_VP), .VER_FRONT (S_VF), .VER_SYNC (S_VS), .VER_TOTAL (S_VT)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (if_small),
    .frame_start (fs_small)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  obs_t q_full[$];
  obs_t q_small[$];

  int f_h = 0, f_v = 0, s_h = 0, s_v = 0;
  bit f_run = 0, s_run = 0;

  bit f_line_ok = 0;
  int hs_cnt = 0, hb_cnt = 0;
  bit s_frame_ok = 0;
  int s_last = 0, vs_cnt = 0, vb_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic obs_t expect_at(bit active, int h, int v, int hp, int hf, int hs,
                                     int vp, int vf, int vs);
    obs_t e = '0;
    if (active) begin
      e.h  = 11'(h);
      e.v  = 11'(v);
      e.hb = (h >= hp);
      e.hs = (h >= hp + hf) && (h < hp + hf + hs);
      e.vb = (v >= vp);
      e.vs = (v >= vp + vf) && (v < vp + vf + vs);
      e.fs = (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic advance(inout int h, inout int v, inout bit run, input int ht, input int vt);
    if (!run) begin
      h = 0; v = 0; run = 1;
    end else if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  function automatic obs_t obs_full();
    return '{if_full.hcount, if_full.vcount, if_full.hsync, if_full.vsync,
             if_full.hblnk, if_full.vblnk, fs_full, if_full.rgb};
  endfunction

  function automatic obs_t obs_small();
    return '{if_small.hcount, if_small.vcount, if_small.hsync, if_small.vsync,
             if_small.hblnk, if_small.vblnk, fs_small, if_small.rgb};
  endfunction

  task automatic model_step();
    if (rst) begin
      f_run = 0; s_run = 0;
    end else begin
      advance(f_h, f_v, f_run, HOR_TOTAL_DEF, VER_TOTAL_DEF);
      advance(s_h, s_v, s_run, S_HT, S_VT);
    end
    q_full.push_back(expect_at(!rst, f_h, f_v, HOR_PIXELS, HOR_FRONT_DEF, HOR_SYNC_DEF,
                               VER_PIXELS, VER_FRONT_DEF, VER_SYNC_DEF));
    q_small.push_back(expect_at(!rst, s_h, s_v, S_HP, S_HF, S_HS, S_VP, S_VF, S_VS));
  endtask

  task automatic compare_sb();
    obs_t e;
    check("sb_full_depth",  64'(q_full.size()),  64'd1);
    check("sb_small_depth", 64'(q_small.size()), 64'd1);
    if (q_full.size() > 0) begin
      e = q_full.pop_front();
      check("sb_full", 64'(obs_full()), 64'(e));
    end
    if (q_small.size() > 0) begin
      e = q_small.pop_front();
      check("sb_small", 64'(obs_small()), 64'(e));
    end
  endtask

  // Per-line and per-frame totals, closed out on each line/frame start
  task automatic track();
    if (rst) begin
      f_line_ok  = 0;
      s_frame_ok = 0;
      return;
    end
    if (if_full.hcount == 11'd0) begin
      if (f_line_ok) begin
        check("hsync_per_line", 64'(hs_cnt), 64'(HOR_SYNC_DEF));
        check("hblnk_per_line", 64'(hb_cnt), 64'(HOR_TOTAL_DEF - HOR_PIXELS));
      end
      hs_cnt = 0; hb_cnt = 0; f_line_ok = 1;
    end
    if (f_line_ok) begin
      hs_cnt += int'(if_full.hsync);
      hb_cnt += int'(if_full.hblnk);
    end
    if (fs_small) begin
      if (s_frame_ok) begin
        check("frame_period",    64'(cyc - s_last), 64'(S_HT * S_VT));
        check("vsync_per_frame", 64'(vs_cnt),       64'(S_VS * S_HT));
        check("vblnk_per_frame", 64'(vb_cnt),       64'((S_VT - S_VP) * S_HT));
      end
      vs_cnt = 0; vb_cnt = 0; s_last = cyc; s_frame_ok = 1;
    end
    if (s_frame_ok) begin
      vs_cnt += int'(if_small.vsync);
      vb_cnt += int'(if_small.vblnk);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare_sb();
    track();
  endtask

  initial begin
    bit found;

    rst = 1'b1;
    repeat (5) tick();
    check("reset_full_zero",  64'(obs_full()),  64'd0);
    check("reset_small_zero", 64'(obs_small()), 64'd0);

    rst = 1'b0;
    tick();
    check("first_hcount", 64'(if_full.hcount), 64'd0);
    check("first_vcount", 64'(if_full.vcount), 64'd0);
    check("first_fs",     64'(fs_full),        64'd1);
    check("first_flags",  64'({if_full.hsync, if_full.vsync, if_full.hblnk, if_full.vblnk}), 64'd0);
    check("first_small",  64'(obs_small()), 64'({22'd0, 5'b00001, 12'd0}));

    repeat (HOR_TOTAL_DEF - 1) tick();
    check("pre_wrap_hcount", 64'(if_full.hcount), 64'd1343);
    check("pre_wrap_vcount", 64'(if_full.vcount), 64'd0);
    check("pre_wrap_hblnk",  64'(if_full.hblnk),  64'd1);
    tick();
    check("wrap_hcount", 64'(if_full.hcount), 64'd0);
    check("wrap_vcount", 64'(if_full.vcount), 64'd1);
    check("wrap_hblnk",  64'(if_full.hblnk),  64'd0);
    check("wrap_no_fs",  64'(fs_full),        64'd0);

    repeat (HOR_TOTAL_DEF + 2) tick();
    check("line2_vcount", 64'(if_full.vcount), 64'd2);

    found = 0;
    for (int i = 0; i < S_HT * S_VT + 2 && !found; i++) begin
      if (if_small.hcount == 11'd13 && if_small.vcount == 11'd7) found = 1;
      else tick();
    end
    check("wait_mid_frame", 64'(found), 64'd1);

    rst = 1'b1;
    tick();
    check("midrst_full_zero",  64'(obs_full()),  64'd0);
    check("midrst_small_zero", 64'(obs_small()), 64'd0);
    rst = 1'b0;
    tick();
    check("restart_small", 64'(obs_small()), 64'({22'd0, 5'b00001, 12'd0}));
    check("restart_full_fs", 64'(fs_full), 64'd1);
    check("restart_full_pos", 64'({if_full.hcount, if_full.vcount}), 64'd0);

    repeat (2 * S_HT * S_VT + 3) tick();
    check("frames_seen", 64'(s_frame_ok), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
